// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: the FSM state type and the
// default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single combinational full-adder cell. The serial adder reuses this one
// cell for every bit position, one bit per clock.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor. One full-adder cell and a carry flop process
// the operands LSB first, one bit per clock. Subtraction is done as
// A + ~B + ~Cin, so the carry-out means "no borrow".
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Ovf
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s;
  logic             fa_co;

  // The only adder in the design: it always looks at the current LSBs and
  // the running carry.
  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state and next-output logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction inverts B and the carry-in, giving A - B - Cin.
          state_d = SHIFT;
          a_d     = A;
          b_d     = B ^ {WIDTH{sub}};
          c_d     = Cin ^ sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        // start is deliberately ignored here; the operation runs to the end.
        sum_d = {fa_s, sum_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_co;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // c_q is the carry into the MSB, fa_co the carry out of it.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          carry_d = fa_co;
          ovf_d   = c_q ^ fa_co;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state registers, with synchronous reset taking priority over start.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the values from
    // before this edge, regardless of statement order.
    if (rst) begin
      // NOTE: the shift registers are cleared too, so Sum reads 0 after reset
      // rather than stale operand bits.
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Sum   = sum_q;
  assign Carry = carry_q;
  assign Ovf   = ovf_q;

endmodule
